cordic_io_fifo: RTL and testbench
=================================

Name: cordic_io_fifo

Overview:
- Buffering and dispatch stage between the AHB-Lite CORDIC bus bridge and the CORDIC datapath core.
- Accepts packed 32-bit operand words from the bridge and queues them in an input FIFO.
- Issues operands to the core under a ready/valid handshake and collects core results in an output FIFO.
- Presents the head result word, a valid flag and an empty flag back to the bridge.

Parameters:
- DEPTH, 4: entries per FIFO; power of two, 2..16.
- INPUT_WIDTH, 16: core operand width; 1..16.
- OUTPUT_WIDTH, 16: core result width; 1..16.

Ports:
- HCLK  in  1  clock
- HRESET  in  1  asynchronous active-high reset
- in_interface  in  32  operand word; x=[31:16], y=[15:0]
- valid_in_interface  in  1  one-cycle write strobe for in_interface
- rd_pop  in  1  one-cycle pulse; bridge consumed out_interface
- out_interface  out  32  head result word; x=[31:16], y=[15:0]
- valid_out_interface  out  1  output FIFO non-empty
- empty  out  1  output FIFO empty (= ~valid_out_interface)
- ovf  out  1  sticky: a write was dropped because the input FIFO was full
- core_x  out  INPUT_WIDTH  operand x to core
- core_y  out  INPUT_WIDTH  operand y to core
- core_valid  out  1  operand valid
- core_ready  in  1  core accepts operand
- core_rx  in  OUTPUT_WIDTH  result x
- core_ry  in  OUTPUT_WIDTH  result y
- core_rvalid  in  1  result valid, one cycle per result

Behaviour:
- Reset and register policy:
  - Clock is HCLK; reset is asynchronous and active-high.
  - HRESET clears both FIFO pointers and counts, the outstanding counter, ovf and the FSM state (state goes to S_IDLE).
  - Reset values: core_valid=0, valid_out_interface=0, empty=1, ovf=0, out_interface=0, core_x=0, core_y=0.
  - Reset mid-operation discards all queued and in-flight data. Core results arriving after reset deassertion while outstanding=0 are dropped.
- Input FIFO:
  - Push on valid_in_interface when in_count<DEPTH. The FIFO stores bits [31:16] and [15:0], each truncated to the low INPUT_WIDTH bits.
  - A push while full is dropped and ovf is set; ovf stays set until reset.
  - Pointers wrap modulo DEPTH. A push and a pop in the same cycle leave the count unchanged.
- Dispatch FSM (states S_IDLE, S_ISSUE):
  - S_IDLE -> S_ISSUE when in_count>0 and credit>0, where credit = DEPTH - out_count - outstanding.
  - In S_ISSUE: core_valid=1, core_x/core_y are registered from the head entry on entry to S_ISSUE and held stable until accepted.
  - On core_valid&core_ready: pop the input FIFO and increment outstanding. The FSM stays in S_ISSUE if another entry and another credit remain; otherwise it returns to S_IDLE.
  - Minimum latency from strobe to core_valid is 2 cycles (push cycle, then FSM entry).
- Result collection:
  - On core_rvalid, push {sign-extended core_rx to 16 bits, sign-extended core_ry to 16 bits} and decrement outstanding.
  - The credit rule guarantees the output FIFO never overflows. A core_rvalid while outstanding=0 is ignored.
  - An issue and a result in the same cycle leave outstanding unchanged.
- Output side:
  - out_interface is registered and equals the head entry whenever valid_out_interface=1, and is 0 when empty.
  - rd_pop advances the head; the new head (or 0) is visible on the next cycle. rd_pop while empty is ignored.
  - A core_rvalid push and an rd_pop in the same cycle are both honoured.
  - First result into an empty FIFO: valid_out_interface rises on the cycle after core_rvalid.
- Counters: in_count and out_count are 0..DEPTH wide (log2(DEPTH)+1 bits); outstanding is 0..DEPTH.

Test Plan:
- Single operation: reset, strobe 0x1234_5678 → core_valid=1 two cycles later with core_x=0x1234, core_y=0x5678. Return core_rx=0xFFFF, core_ry=0x0001 → next cycle valid_out=1, empty=0, out_interface=0xFFFF_0001. rd_pop → empty=1, out_interface=0.
- Back-pressure: hold core_ready=0 and strobe 4 words → core_x/core_y stay at word 0. A 5th strobe sets ovf=1 and in_count stays 4. Release core_ready → 4 issues on consecutive cycles, in order.
- Credit limit: DEPTH=4, never rd_pop, 6 words fed with immediate results → exactly 4 results in the output FIFO and core_valid stays 0. Two rd_pops → two more issues, output order matches input order.
- Simultaneous events: same-cycle strobe+issue and core_rvalid+rd_pop → counts unchanged. Pointer wrap after 10 operations shows no loss or duplication (scoreboard check).
- Reset mid-operation: assert HRESET with 2 queued and 1 outstanding → all outputs return to reset values immediately. A later stray core_rvalid is dropped and empty stays 1.

Source files
------------

// File: rtl/cordic_io_fifo.sv
// Buffer and dispatch stage between the CORDIC bus bridge and the CORDIC core.
// Operand words are queued in an input FIFO and sent to the core over a
// ready/valid handshake. Core results are sign-extended and queued in an
// output FIFO. The head of the output FIFO is presented back to the bridge.
// An operand is issued only when a slot is already guaranteed for its result
// (credit = DEPTH - out_count - outstanding), so the output FIFO cannot overflow.
//
// state   | meaning
// S_IDLE  | nothing presented to the core
// S_ISSUE | core_valid high, core_x/core_y hold the input FIFO head

module cordic_io_fifo #(
    parameter int DEPTH        = 4,
    parameter int INPUT_WIDTH  = 16,
    parameter int OUTPUT_WIDTH = 16
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic [31:0]             in_interface,
    input  logic                    valid_in_interface,
    input  logic                    rd_pop,
    output logic [31:0]             out_interface,
    output logic                    valid_out_interface,
    output logic                    empty,
    output logic                    ovf,
    output logic [INPUT_WIDTH-1:0]  core_x,
    output logic [INPUT_WIDTH-1:0]  core_y,
    output logic                    core_valid,
    input  logic                    core_ready,
    input  logic [OUTPUT_WIDTH-1:0] core_rx,
    input  logic [OUTPUT_WIDTH-1:0] core_ry,
    input  logic                    core_rvalid
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t                 state_q;
    logic                   core_valid_q;
    logic [INPUT_WIDTH-1:0] core_x_q, core_y_q;

    logic [INPUT_WIDTH-1:0] in_mem_x [DEPTH];
    logic [INPUT_WIDTH-1:0] in_mem_y [DEPTH];
    logic [PW-1:0]          in_wr_q, in_wr_d, in_rd_q, in_rd_d, in_rd_nxt;
    logic [CW-1:0]          in_cnt_q, in_cnt_d;
    logic                   ovf_q;

    logic [31:0]            out_mem [DEPTH];
    logic [PW-1:0]          out_wr_q, out_wr_d, out_rd_q, out_rd_d;
    logic [CW-1:0]          out_cnt_q, out_cnt_d;
    logic [31:0]            out_head_q, out_head_d;

    logic [CW-1:0]          outst_q, outst_d;

    logic                   in_push, issue, rx_acc, out_push, out_pop;
    logic                   credit_ok_q, credit_ok_d;
    logic [31:0]            rx_word;

    assign core_valid          = core_valid_q;
    assign core_x              = core_x_q;
    assign core_y              = core_y_q;
    assign ovf                 = ovf_q;
    assign out_interface       = out_head_q;
    assign valid_out_interface = (out_cnt_q != '0);
    assign empty               = (out_cnt_q == '0);

    // Next-state of both FIFOs, the outstanding counter and the output head.
    always_comb begin
        issue     = core_valid_q && core_ready;
        in_push   = valid_in_interface && (in_cnt_q != DEPTH_C);
        in_rd_nxt = in_rd_q + PW'(1);
        in_wr_d   = in_push ? in_wr_q + PW'(1) : in_wr_q;
        in_rd_d   = issue ? in_rd_nxt : in_rd_q;
        in_cnt_d  = in_cnt_q + CW'(in_push) - CW'(issue);

        rx_acc    = core_rvalid && (outst_q != '0);
        outst_d   = outst_q + CW'(issue) - CW'(rx_acc);
        rx_word   = {16'($signed(core_rx)), 16'($signed(core_ry))};

        out_push  = rx_acc && (out_cnt_q != DEPTH_C);
        out_pop   = rd_pop && (out_cnt_q != '0);
        out_wr_d  = out_push ? out_wr_q + PW'(1) : out_wr_q;
        out_rd_d  = out_pop ? out_rd_q + PW'(1) : out_rd_q;
        out_cnt_d = out_cnt_q + CW'(out_push) - CW'(out_pop);

        credit_ok_q = ({1'b0, out_cnt_q} + {1'b0, outst_q}) < DEPTH_W;
        credit_ok_d = ({1'b0, out_cnt_d} + {1'b0, outst_d}) < DEPTH_W;

        // The new head is the incoming result when nothing older survives the pop.
        out_head_d = '0;
        if (out_cnt_d != '0) begin
            if (out_push && ((out_cnt_q - CW'(out_pop)) == '0)) begin
                out_head_d = rx_word;
            end else begin
                out_head_d = out_mem[out_rd_d];
            end
        end
    end

    // Storage arrays; contents need no reset because counts gate every read.
    always_ff @(posedge HCLK) begin
        if (in_push) begin
            in_mem_x[in_wr_q] <= in_interface[16 +: INPUT_WIDTH];
            in_mem_y[in_wr_q] <= in_interface[0 +: INPUT_WIDTH];
        end
        if (out_push) begin
            out_mem[out_wr_q] <= rx_word;
        end
    end

    // Pointers, counts, outstanding counter, sticky overflow and output head.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            in_wr_q    <= '0;
            in_rd_q    <= '0;
            in_cnt_q   <= '0;
            out_wr_q   <= '0;
            out_rd_q   <= '0;
            out_cnt_q  <= '0;
            outst_q    <= '0;
            ovf_q      <= 1'b0;
            out_head_q <= '0;
        end else begin
            in_wr_q    <= in_wr_d;
            in_rd_q    <= in_rd_d;
            in_cnt_q   <= in_cnt_d;
            out_wr_q   <= out_wr_d;
            out_rd_q   <= out_rd_d;
            out_cnt_q  <= out_cnt_d;
            outst_q    <= outst_d;
            out_head_q <= out_head_d;
            if (valid_in_interface && !in_push) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Dispatch FSM: loads the operand on entry and after each accepted issue.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q      <= S_IDLE;
            core_valid_q <= 1'b0;
            core_x_q     <= '0;
            core_y_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if ((in_cnt_q != '0) && credit_ok_q) begin
                        state_q      <= S_ISSUE;
                        core_valid_q <= 1'b1;
                        core_x_q     <= in_mem_x[in_rd_q];
                        core_y_q     <= in_mem_y[in_rd_q];
                    end
                end
                S_ISSUE: begin
                    if (core_ready) begin
                        // Back-to-back only when the next entry is already stored.
                        if ((in_cnt_q > CW'(1)) && credit_ok_d) begin
                            core_x_q <= in_mem_x[in_rd_nxt];
                            core_y_q <= in_mem_y[in_rd_nxt];
                        end else begin
                            state_q      <= S_IDLE;
                            core_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    core_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_io_fifo.sv
// Bench for cordic_io_fifo: directed scenarios plus random traffic, all checked
// against a queue-based model of the operand queue, in-flight count and result queue.

module tb_cordic_io_fifo;

    localparam int DEPTH = 4;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b0;
    logic [31:0] in_interface = '0;
    logic        valid_in_interface = 1'b0;
    logic        rd_pop = 1'b0;
    logic [31:0] out_interface;
    logic        valid_out_interface;
    logic        empty;
    logic        ovf;
    logic [15:0] core_x, core_y;
    logic        core_valid;
    logic        core_ready = 1'b0;
    logic [15:0] core_rx = '0, core_ry = '0;
    logic        core_rvalid = 1'b0;

    cordic_io_fifo #(.DEPTH(DEPTH), .INPUT_WIDTH(16), .OUTPUT_WIDTH(16)) dut (
        .HCLK               (HCLK),
        .HRESET             (HRESET),
        .in_interface       (in_interface),
        .valid_in_interface (valid_in_interface),
        .rd_pop             (rd_pop),
        .out_interface      (out_interface),
        .valid_out_interface(valid_out_interface),
        .empty              (empty),
        .ovf                (ovf),
        .core_x             (core_x),
        .core_y             (core_y),
        .core_valid         (core_valid),
        .core_ready         (core_ready),
        .core_rx            (core_rx),
        .core_ry            (core_ry),
        .core_rvalid        (core_rvalid)
    );

    always #5 HCLK = ~HCLK;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model
    logic [31:0] in_q[$];
    logic [31:0] out_q[$];
    int          outst = 0;
    bit          ovf_m = 1'b0;
    int          n_issue = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        in_q.delete();
        out_q.delete();
        outst = 0;
        ovf_m = 1'b0;
    endtask

    // One clock: capture pre-edge handshake, advance the model, compare outputs.
    task automatic cycle();
        logic        pv;
        logic [15:0] px, py;
        logic        issued, acc, rv_acc, popd;
        pv = core_valid;
        px = core_x;
        py = core_y;
        @(posedge HCLK);
        #1;
        issued = pv && core_ready;
        rv_acc = core_rvalid && (outst > 0);
        acc    = valid_in_interface && (in_q.size() < DEPTH);
        popd   = rd_pop && (out_q.size() > 0);
        if (valid_in_interface && !acc) ovf_m = 1'b1;
        if (issued) begin
            n_issue++;
            check("issue_has_data", 32'(in_q.size() != 0), 1);
            if (in_q.size() != 0) begin
                check("issue_x", px, in_q[0][31:16]);
                check("issue_y", py, in_q[0][15:0]);
                void'(in_q.pop_front());
            end
        end
        if (acc) in_q.push_back(in_interface);
        if (popd) void'(out_q.pop_front());
        if (rv_acc) out_q.push_back({core_rx, core_ry});
        outst = outst + int'(issued) - int'(rv_acc);

        check("credit", 32'((out_q.size() + outst) <= DEPTH), 1);
        check("valid_out", valid_out_interface, 32'(out_q.size() != 0));
        check("empty", empty, 32'(out_q.size() == 0));
        check("out_word", out_interface, (out_q.size() != 0) ? out_q[0] : 32'h0);
        check("ovf", ovf, ovf_m);
        if (core_valid) begin
            check("cv_has_data", 32'(in_q.size() != 0), 1);
            if (in_q.size() != 0) begin
                check("cv_x", core_x, in_q[0][31:16]);
                check("cv_y", core_y, in_q[0][15:0]);
            end
        end
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        #1;
        check("rst_core_valid", core_valid, 0);
        check("rst_valid_out", valid_out_interface, 0);
        check("rst_empty", empty, 1);
        check("rst_ovf", ovf, 0);
        check("rst_out", out_interface, 0);
        check("rst_core_x", core_x, 0);
        check("rst_core_y", core_y, 0);
        model_clear();
        valid_in_interface = 1'b0;
        rd_pop = 1'b0;
        core_rvalid = 1'b0;
        core_ready = 1'b0;
        @(posedge HCLK);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        valid_in_interface = 1'b0;
        core_ready = 1'b1;
        rd_pop = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            core_rvalid = (outst > 0);
            core_rx = 16'($urandom);
            core_ry = 16'($urandom);
            cycle();
            done = (in_q.size() == 0) && (outst == 0) && (out_q.size() == 0) && !core_valid;
        end
        check("drain_done", 32'(done), 1);
        rd_pop = 1'b0;
        core_rvalid = 1'b0;
        core_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w[4];
        int          base;
        #2;
        do_reset();

        // single operation with latency and sign/format checks
        valid_in_interface = 1'b1;
        in_interface = 32'h1234_5678;
        cycle();
        valid_in_interface = 1'b0;
        check("t1_lat1", core_valid, 0);
        cycle();
        check("t1_valid", core_valid, 1);
        check("t1_x", core_x, 32'h1234);
        check("t1_y", core_y, 32'h5678);
        core_ready = 1'b1;
        cycle();
        core_ready = 1'b0;
        check("t1_accepted", core_valid, 0);
        core_rvalid = 1'b1;
        core_rx = 16'hFFFF;
        core_ry = 16'h0001;
        cycle();
        core_rvalid = 1'b0;
        check("t1_vout", valid_out_interface, 1);
        check("t1_not_empty", empty, 0);
        check("t1_word", out_interface, 32'hFFFF_0001);
        rd_pop = 1'b1;
        cycle();
        rd_pop = 1'b0;
        check("t1_pop_empty", empty, 1);
        check("t1_pop_word", out_interface, 0);

        // back-pressure, overflow, then back-to-back issue
        do_reset();
        for (int i = 0; i < 4; i++) begin
            w[i] = $urandom;
            in_interface = w[i];
            valid_in_interface = 1'b1;
            cycle();
        end
        check("t2_hold_x", core_x, {16'h0, w[0][31:16]});
        in_interface = $urandom;
        cycle();
        valid_in_interface = 1'b0;
        check("t2_ovf", ovf, 1);
        check("t2_still_x", core_x, {16'h0, w[0][31:16]});
        core_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t2_b2b_valid", core_valid, 1);
            check("t2_b2b_x", core_x, {16'h0, w[i][31:16]});
            check("t2_b2b_y", core_y, {16'h0, w[i][15:0]});
            cycle();
        end
        core_ready = 1'b0;
        check("t2_done", core_valid, 0);
        drain();
        check("t2_ovf_sticky", ovf, 1);

        // credit limit with no reads
        do_reset();
        base = n_issue;
        core_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            valid_in_interface = (c < 6);
            in_interface = $urandom;
            core_rvalid = (outst > 0);
            core_rx = 16'($urandom);
            core_ry = 16'($urandom);
            cycle();
        end
        valid_in_interface = 1'b0;
        core_rvalid = 1'b0;
        check("t3_stalled", core_valid, 0);
        check("t3_issued4", n_issue - base, 4);
        check("t3_vout", valid_out_interface, 1);
        rd_pop = 1'b1;
        cycle();
        cycle();
        rd_pop = 1'b0;
        for (int c = 0; c < 10; c++) begin
            core_rvalid = (outst > 0);
            core_rx = 16'($urandom);
            core_ry = 16'($urandom);
            cycle();
        end
        core_rvalid = 1'b0;
        check("t3_issued6", n_issue - base, 6);
        drain();

        // reset with queued and in-flight data, then a stray result
        do_reset();
        valid_in_interface = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_interface = $urandom;
            cycle();
        end
        valid_in_interface = 1'b0;
        check("t4_valid", core_valid, 1);
        core_ready = 1'b1;
        cycle();
        core_ready = 1'b0;
        check("t4_outst", outst, 1);
        do_reset();
        core_rvalid = 1'b1;
        core_rx = 16'h8000;
        core_ry = 16'h7FFF;
        cycle();
        core_rvalid = 1'b0;
        check("t4_stray_empty", empty, 1);
        check("t4_stray_vout", valid_out_interface, 0);

        // random traffic (same-cycle strobe/issue, rvalid/pop, pointer wrap)
        do_reset();
        base = n_issue;
        for (int c = 0; c < 800; c++) begin
            valid_in_interface = ($urandom_range(0, 99) < 50);
            in_interface = $urandom;
            core_ready = ($urandom_range(0, 99) < 60);
            rd_pop = ($urandom_range(0, 99) < 40);
            if (outst > 0) core_rvalid = ($urandom_range(0, 99) < 50);
            else           core_rvalid = ($urandom_range(0, 99) < 3);
            core_rx = 16'($urandom);
            core_ry = 16'($urandom);
            cycle();
        end
        drain();
        check("t5_many_issued", 32'((n_issue - base) >= 10), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
